// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//
// Byte FIFO plus launch controller that sits directly upstream of the UART
// transmitter. The host pushes bytes at full clock rate; the controller hands
// them to the transmitter one at a time over the go / data / busy handshake,
// so software can queue a burst without polling busy between bytes.
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   host write strobe, one byte per cycle
//   wr_data  in   [7:0] byte to enqueue
//   full     out  queue holds DEPTH bytes
//   empty    out  queue holds no bytes
//   tx_busy  in   transmitter busy flag
//   tx_go    out  one-cycle launch pulse to the transmitter
//   tx_data  out  [7:0] byte presented to the transmitter
//
// Optional build macro UART_TXQ_STATUS_EN adds:
//   level    out  [ADDR_W:0] current number of queued bytes
//   overflow out  sticky flag, set when a write is dropped while full;
//                 cleared only by rst_n
//
// Parameters:
//   DEPTH    number of byte entries, power of two, minimum 2
//   ADDR_W   pointer width, must equal log2(DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    input  logic              tx_busy,
    output logic              tx_go,
    output logic [7:0]        tx_data
`ifdef UART_TXQ_STATUS_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              overflow
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [1:0]        state_q,  state_d;
    logic              tx_go_q,  tx_go_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic wr_accept;
    logic pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // full comes from the registered count, so a write into a full queue is
    // refused even when a pop frees a slot on the same edge.
    assign wr_accept = wr_en && !full;

    // Launch controller. tx_data only changes on a launch, so the byte stays
    // stable for the transmitter for the whole transfer.
    always_comb begin
        state_d   = state_q;
        tx_go_d   = 1'b0;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    tx_go_d   = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the pointers and count define which entries
    // are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            tx_go_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_go_q   <= tx_go_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_go   = tx_go_q;
    assign tx_data = tx_data_q;

`ifdef UART_TXQ_STATUS_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign level    = count_q;
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Self-checking bench for uart_tx_queue. A reference model tracks queue
// occupancy and the launch/handshake rules at transaction level; accepted
// bytes go into a scoreboard queue that a monitor drains whenever the DUT
// launches. A simple transmitter model raises busy one cycle after each
// accepted go and holds it for a configurable time (or indefinitely).
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        full;
    logic        empty;
    logic        tx_go;
    logic [7:0]  tx_data;
`ifdef UART_TXQ_STATUS_EN
    logic [ADDR_W:0] level;
    logic            overflow;
`endif

    uart_tx_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .tx_busy (tx_busy),
        .tx_go   (tx_go),
        .tx_data (tx_data)
`ifdef UART_TXQ_STATUS_EN
        ,
        .level    (level),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model. occ = bytes held; phase 0 = launcher free,
    // 1 = launched and waiting to see busy, 2 = waiting for busy to end.
    // ------------------------------------------------------------------
    int         occ    = 0;
    int         phase  = 0;
    bit         go_exp = 1'b0;
    bit         ovf    = 1'b0;
    bit         m_acc;
    bit         m_launch;
    logic [7:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    = 0;
            phase  = 0;
            go_exp = 1'b0;
            ovf    = 1'b0;
            exp_q.delete();
        end else begin
            m_acc    = wr_en && (occ < DEPTH);
            m_launch = (phase == 0) && (occ > 0);
            if (wr_en && !m_acc) ovf = 1'b1;
            if (m_acc) exp_q.push_back(wr_data);
            go_exp = m_launch;
            occ    = occ + int'(m_acc) - int'(m_launch);
            if (phase == 0 && m_launch)     phase = 1;
            else if (phase == 1 && tx_busy) phase = 2;
            else if (phase == 2 && !tx_busy) phase = 0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor + transmitter model (negedge, away from the active edge).
    // ------------------------------------------------------------------
    int         busy_len   = 20;
    int         busy_cnt   = 0;
    bit         start_pend = 1'b0;
    bit         hold       = 1'b0;
    bit         busy_now;
    logic [7:0] last_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy    = 1'b0;
            busy_cnt   = 0;
            start_pend = 1'b0;
            last_data  = 8'h00;
        end else begin
            busy_now = tx_busy;
            chk("tx_go", int'(tx_go), int'(go_exp));
            chk("full", int'(full), int'(occ == DEPTH));
            chk("empty", int'(empty), int'(occ == 0));
`ifdef UART_TXQ_STATUS_EN
            chk("level", int'(level), occ);
            chk("overflow", int'(overflow), int'(ovf));
`endif
            chk("go_while_busy", int'(tx_go && busy_now), 0);
            if (tx_go) begin
                chk("sb_has_byte", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    last_data = exp_q.pop_front();
                    chk("tx_data", int'(tx_data), int'(last_data));
                end
            end else begin
                chk("tx_data_hold", int'(tx_data), int'(last_data));
            end
            if (start_pend) begin
                tx_busy    = 1'b1;
                busy_cnt   = busy_len;
                start_pend = 1'b0;
            end else if (tx_busy && !hold) begin
                busy_cnt--;
                if (busy_cnt <= 0) tx_busy = 1'b0;
            end
            if (tx_go && !busy_now) start_pend = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_busy_seen();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (phase == 2) break;
        end
        chk("wait_busy_seen", phase, 2);
    endtask

    task automatic drain();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (occ == 0 && phase == 0) break;
        end
        repeat (2) @(negedge clk);
        chk("drain_sb_empty", int'(exp_q.size()), 0);
    endtask

    initial begin
        // Writes during reset are ignored.
        repeat (2) @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_go", int'(tx_go), 0);
        chk("rst_data", int'(tx_data), 0);

        // Single byte: go one edge after the write edge, one cycle wide.
        busy_len = 20;
        wr(8'hAB);
        idle();
        @(negedge clk);
        chk("lat_go", int'(tx_go), 1);
        chk("lat_data", int'(tx_data), 8'hAB);
        chk("lat_empty", int'(empty), 1);
        @(negedge clk);
        chk("pulse_width", int'(tx_go), 0);
        drain();

        // Back-to-back burst.
        busy_len = 3;
        for (int i = 1; i <= 5; i++) wr(8'(i));
        idle();
        drain();

        // Fill while the transmitter is stuck busy, then overflow.
        busy_len = 2;
        hold     = 1'b1;
        wr(8'h10);
        idle();
        wait_busy_seen();
        for (int i = 0; i < DEPTH; i++) wr(8'h20 + 8'(i));
        wr(8'hFF);
        idle();
        chk("fill_full", int'(full), 1);
`ifdef UART_TXQ_STATUS_EN
        chk("fill_overflow", int'(overflow), 1);
        chk("fill_level", int'(level), DEPTH);
`endif
        // Release the transmitter and keep writing across the pointer wrap;
        // writes that land while full (including on a pop edge) are dropped.
        hold = 1'b0;
        for (int i = 0; i < 40; i++) wr(8'h40 + 8'(i));
        idle();
        drain();

        // Reset while waiting for busy to fall with bytes still queued.
        hold = 1'b1;
        wr(8'h70);
        idle();
        wait_busy_seen();
        wr(8'h71);
        wr(8'h72);
        wr(8'h73);
        idle();
        chk("pre_rst_empty", int'(empty), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_go", int'(tx_go), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_data", int'(tx_data), 0);
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_empty", int'(empty), 1);

        // Randomized traffic with random transfer lengths.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            busy_len = int'($urandom_range(1, 5));
            wr_en    = ($urandom_range(0, 99) < 35);
            wr_data  = 8'($urandom);
        end
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
